// File: rtl/rvvi_slowframe_rx.sv
// Receive-side decoder for RVVI host slow-down frames: matches the header on the
// MAC receive stream, captures the fill amount and pulses a request per valid frame.
module rvvi_slowframe_rx #(
  parameter logic [47:0] LOCAL_MAC  = 48'h0000_0000_0000,
  parameter logic [47:0] HOST_MAC   = 48'h0000_0000_0000,
  parameter logic [15:0] ETHER_TYPE = 16'h005C,
  parameter logic [15:0] SLOW_TAG   = 16'h0001
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] RxTData,
  input  logic [3:0]  RxTKeep,
  input  logic        RxTValid,
  input  logic        RxTLast,
  input  logic        RxTUser,
  output logic        RxTReady,
  output logic        HostRequestSlowDown,
  output logic [31:0] HostFiFoFillAmt,
  output logic [15:0] FramesAccepted,
  output logic [15:0] FramesRejected
);

  typedef enum logic [2:0] {
    IDLE,
    MATCH,
    CAPTURE,
    DRAIN,
    REJECT
  } rxState_t;

  rxState_t    state;
  rxState_t    stateNext;
  logic [2:0]  beatIdx;
  logic [31:0] fillShadow;
  logic [31:0] expectedWord;
  logic        beatFire;
  logic        beatMatch;
  logic        frameOk;
  logic        acceptFrame;
  logic        rejectFrame;

  assign beatFire  = RxTValid & RxTReady;
  assign beatMatch = (RxTData == expectedWord);
  assign frameOk   = ~RxTUser & (|RxTKeep);

  // Header words in little-endian lane order; beats 4+ are never compared.
  always_comb begin
    expectedWord = '0;
    case (beatIdx)
      3'd0:    expectedWord = LOCAL_MAC[31:0];
      3'd1:    expectedWord = {HOST_MAC[15:0], LOCAL_MAC[47:32]};
      3'd2:    expectedWord = HOST_MAC[47:16];
      3'd3:    expectedWord = {SLOW_TAG, ETHER_TYPE};
      default: expectedWord = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext   = state;
    acceptFrame = 1'b0;
    rejectFrame = 1'b0;
    if (beatFire) begin
      case (state)
        IDLE: begin
          if (RxTLast) begin
            rejectFrame = 1'b1;
          end else begin
            stateNext = beatMatch ? MATCH : REJECT;
          end
        end
        MATCH: begin
          if (RxTLast) begin
            rejectFrame = 1'b1;
            stateNext   = IDLE;
          end else if (!beatMatch) begin
            stateNext = REJECT;
          end else if (beatIdx == 3'd3) begin
            stateNext = CAPTURE;
          end
        end
        CAPTURE, DRAIN: begin
          if (RxTLast) begin
            acceptFrame = frameOk;
            rejectFrame = ~frameOk;
            stateNext   = IDLE;
          end else begin
            stateNext = DRAIN;
          end
        end
        REJECT: begin
          if (RxTLast) begin
            rejectFrame = 1'b1;
            stateNext   = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      RxTReady            <= 1'b0;
      beatIdx             <= 3'd0;
      fillShadow          <= '0;
      HostRequestSlowDown <= 1'b0;
      HostFiFoFillAmt     <= '0;
      FramesAccepted      <= '0;
      FramesRejected      <= '0;
    end else begin
      RxTReady            <= 1'b1;
      HostRequestSlowDown <= acceptFrame;
      if (beatFire) begin
        if (RxTLast) begin
          beatIdx <= 3'd0;
        end else if (beatIdx != 3'd7) begin
          beatIdx <= beatIdx + 3'd1;
        end
      end
      if (beatFire && state == CAPTURE) begin
        fillShadow <= RxTData;
      end
      // A frame ending on beat 4 has not yet written the shadow, so take the bus.
      if (acceptFrame) begin
        HostFiFoFillAmt <= (state == CAPTURE) ? RxTData : fillShadow;
        FramesAccepted  <= FramesAccepted + 16'd1;
      end
      if (rejectFrame) begin
        FramesRejected <= FramesRejected + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rvvi_slowframe_rx.sv
// Directed bench for rvvi_slowframe_rx: a byte-level frame model predicts every
// output each cycle, plus literal checks after each scenario.
module tb_rvvi_slowframe_rx;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] RxTData;
  logic [3:0]  RxTKeep;
  logic        RxTValid;
  logic        RxTLast;
  logic        RxTUser;
  logic        RxTReady;
  logic        HostRequestSlowDown;
  logic [31:0] HostFiFoFillAmt;
  logic [15:0] FramesAccepted;
  logic [15:0] FramesRejected;

  always #5 clk = ~clk;

  // Wire order 02:00:00:00:00:01 and 02:00:00:00:00:02, first byte in [7:0].
  rvvi_slowframe_rx #(
    .LOCAL_MAC (48'h0100_0000_0002),
    .HOST_MAC  (48'h0200_0000_0002),
    .ETHER_TYPE(16'h005C),
    .SLOW_TAG  (16'h0001)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .RxTData            (RxTData),
    .RxTKeep            (RxTKeep),
    .RxTValid           (RxTValid),
    .RxTLast            (RxTLast),
    .RxTUser            (RxTUser),
    .RxTReady           (RxTReady),
    .HostRequestSlowDown(HostRequestSlowDown),
    .HostFiFoFillAmt    (HostFiFoFillAmt),
    .FramesAccepted     (FramesAccepted),
    .FramesRejected     (FramesRejected)
  );

  // Expected header in wire-byte order: dst MAC, src MAC, EtherType, tag.
  logic [7:0] hdr [0:15] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                             8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
                             8'h5C, 8'h00, 8'h01, 8'h00};

  int nCompared = 0;
  int nMismatch = 0;
  int pulseCnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collect wire bytes, judge the whole frame at its last beat.
  logic        expReady = 1'b0;
  logic        expPulse = 1'b0;
  logic [31:0] expFill  = '0;
  logic [15:0] expAcc   = '0;
  logic [15:0] expRej   = '0;
  logic [7:0]  rxBytes [$];
  int          rxBeats  = 0;
  logic        mHs;
  logic        mOk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      expReady = 1'b0;
      expPulse = 1'b0;
      expFill  = '0;
      expAcc   = '0;
      expRej   = '0;
      rxBytes.delete();
      rxBeats  = 0;
    end else begin
      mHs      = RxTValid && expReady;
      expPulse = 1'b0;
      if (mHs) begin
        for (int k = 0; k < 4; k++) rxBytes.push_back(RxTData[8*k +: 8]);
        rxBeats++;
        if (RxTLast) begin
          mOk = (rxBeats >= 5) && !RxTUser && (RxTKeep != 4'h0);
          if (rxBeats >= 5) begin
            for (int j = 0; j < 16; j++) if (rxBytes[j] != hdr[j]) mOk = 1'b0;
          end
          if (mOk) begin
            expPulse = 1'b1;
            expFill  = {rxBytes[19], rxBytes[18], rxBytes[17], rxBytes[16]};
            expAcc   = expAcc + 16'd1;
          end else begin
            expRej = expRej + 16'd1;
          end
          rxBytes.delete();
          rxBeats = 0;
        end
      end
      expReady = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("RxTReady", {31'd0, RxTReady}, {31'd0, expReady});
    check("HostRequestSlowDown", {31'd0, HostRequestSlowDown}, {31'd0, expPulse});
    check("HostFiFoFillAmt", HostFiFoFillAmt, expFill);
    check("FramesAccepted", {16'd0, FramesAccepted}, {16'd0, expAcc});
    check("FramesRejected", {16'd0, FramesRejected}, {16'd0, expRej});
    if (HostRequestSlowDown === 1'b1) pulseCnt++;
  end

  task automatic idle(input int n);
    RxTValid = 1'b0;
    RxTLast  = 1'b0;
    RxTUser  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the last beat's edge.
  task automatic sendFrame(input int nBeats, input logic [31:0] fill, input logic badEther,
                           input logic user, input logic [3:0] keepLast, input int gap,
                           input int resetAt);
    logic [7:0] fb [0:63];
    for (int i = 0; i < 64; i++) fb[i] = 8'(i) ^ 8'hA5;
    for (int i = 0; i < 16; i++) fb[i] = hdr[i];
    if (badEther) fb[12] = 8'h5D;
    for (int i = 0; i < 4; i++) fb[16+i] = fill[8*i +: 8];
    $display("frame: beats=%0d fill=%h badEther=%0b user=%0b keepLast=%h gap=%0d resetAt=%0d",
             nBeats, fill, badEther, user, keepLast, gap, resetAt);
    for (int b = 0; b < nBeats; b++) begin
      RxTData  = {fb[4*b+3], fb[4*b+2], fb[4*b+1], fb[4*b]};
      RxTValid = 1'b1;
      RxTLast  = (b == nBeats - 1);
      RxTKeep  = (b == nBeats - 1) ? keepLast : 4'hF;
      RxTUser  = (b == nBeats - 1) ? user : 1'b0;
      if (b == resetAt) begin
        #2 resetn = 1'b0;
        #1;
        check("rst_RxTReady", {31'd0, RxTReady}, 32'd0);
        check("rst_pulse", {31'd0, HostRequestSlowDown}, 32'd0);
        check("rst_fill", HostFiFoFillAmt, 32'd0);
        check("rst_accepted", {16'd0, FramesAccepted}, 32'd0);
        check("rst_rejected", {16'd0, FramesRejected}, 32'd0);
        #2 resetn = 1'b1;
      end
      @(posedge clk);
      #1;
      if (b != nBeats - 1 && gap > 0) begin
        RxTValid = 1'b0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
    RxTValid = 1'b0;
    RxTLast  = 1'b0;
    RxTUser  = 1'b0;
  endtask

  task automatic expectState(input string tag, input logic [31:0] fill, input int acc,
                             input int rej, input int pulses);
    check({tag, "_fill"}, HostFiFoFillAmt, fill);
    check({tag, "_accepted"}, {16'd0, FramesAccepted}, 32'(acc));
    check({tag, "_rejected"}, {16'd0, FramesRejected}, 32'(rej));
    check({tag, "_pulses"}, 32'(pulseCnt), 32'(pulses));
  endtask

  initial begin
    resetn   = 1'b0;
    RxTData  = '0;
    RxTKeep  = 4'h0;
    RxTValid = 1'b0;
    RxTLast  = 1'b0;
    RxTUser  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_RxTReady", {31'd0, RxTReady}, 32'd0);
    expectState("reset", 32'h0, 0, 0, 0);
    resetn = 1'b1;
    idle(2);
    check("ready_after_reset", {31'd0, RxTReady}, 32'd1);

    sendFrame(15, 32'h0300_0010, 1'b0, 1'b0, 4'hF, 0, -1);
    check("t1_pulse_next_cycle", {31'd0, HostRequestSlowDown}, 32'd1);
    idle(3);
    expectState("t1", 32'h0300_0010, 1, 0, 1);

    sendFrame(15, 32'h0000_5555, 1'b1, 1'b0, 4'hF, 0, -1);
    idle(3);
    expectState("t2", 32'h0300_0010, 1, 1, 1);

    sendFrame(3, 32'h0, 1'b0, 1'b0, 4'hF, 0, -1);
    sendFrame(15, 32'h0000_0ABC, 1'b0, 1'b0, 4'hF, 0, -1);
    idle(3);
    expectState("t3", 32'h0000_0ABC, 2, 2, 2);

    sendFrame(15, 32'h1111_2222, 1'b0, 1'b1, 4'hF, 0, -1);
    idle(3);
    expectState("t4", 32'h0000_0ABC, 2, 3, 2);

    sendFrame(5, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'h1, 3, -1);
    idle(3);
    expectState("t5", 32'hDEAD_BEEF, 3, 3, 3);

    sendFrame(6, 32'h7777_7777, 1'b0, 1'b0, 4'h0, 0, -1);
    idle(3);
    expectState("t6", 32'hDEAD_BEEF, 3, 4, 3);

    sendFrame(5, 32'h0000_0001, 1'b0, 1'b0, 4'hF, 0, -1);
    sendFrame(5, 32'h0000_0002, 1'b0, 1'b0, 4'hF, 0, -1);
    idle(3);
    expectState("t7", 32'h0000_0002, 5, 4, 5);

    sendFrame(15, 32'h0300_0010, 1'b0, 1'b0, 4'hF, 0, 3);
    idle(3);
    expectState("t8", 32'h0, 0, 1, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
